// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus interface unit: access sizes, FSM states,
// requesting channel, and the alignment rule used by the FSM and lane logic.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        CH_IF = 1'b0,
        CH_D  = 1'b1
    } chan_e;

    // A dword access is only legal on a 64-bit bus.
    function automatic logic is_misaligned(input size_e sz, input logic [2:0] off,
                                           input logic wide);
        logic m;
        case (sz)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = off[0];
            SZ_WORD: m = |off[1:0];
            default: m = !wide || (|off);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mips_bus_lane.sv
// Combinational lane logic: little-endian byteenable and write-data placement,
// load extraction with sign/zero extension, and misalignment detection.
module mips_bus_lane
    import mips_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_e                         sz_i,
    input  logic [$clog2(DATA_W/8)-1:0]   off_i,
    input  logic                          signed_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic [DATA_W-1:0]             rdata_i,
    output logic [DATA_W/8-1:0]           be_o,
    output logic [DATA_W-1:0]             wdata_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          misaligned_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    logic [DATA_W-1:0] size_mask;
    logic [DATA_W-1:0] rd_shift;
    logic [BE_W-1:0]   be_mask;
    logic              sign_bit;
    logic [OFF_W+2:0]  shamt;

    // Size-dependent masks, then shift into / out of the addressed lanes.
    always_comb begin
        shamt     = {off_i, 3'b000};
        rd_shift  = rdata_i >> shamt;
        size_mask = '0;
        be_mask   = '0;
        sign_bit  = 1'b0;
        case (sz_i)
            SZ_BYTE: begin
                be_mask        = BE_W'(1);
                size_mask[7:0] = '1;
                sign_bit       = rd_shift[7];
            end
            SZ_HALF: begin
                be_mask         = BE_W'(3);
                size_mask[15:0] = '1;
                sign_bit        = rd_shift[15];
            end
            SZ_WORD: begin
                be_mask         = BE_W'(15);
                size_mask[31:0] = '1;
                sign_bit        = rd_shift[31];
            end
            default: begin
                be_mask   = '1;
                size_mask = '1;
                sign_bit  = rd_shift[DATA_W-1];
            end
        endcase
        be_o         = be_mask << off_i;
        wdata_o      = (wdata_i & size_mask) << shamt;
        rdata_o      = (rd_shift & size_mask) | ((signed_i && sign_bit) ? ~size_mask : '0);
        misaligned_o = is_misaligned(sz_i, 3'(off_i), DATA_W == 64);
    end

endmodule

// File: rtl/mips_bus_if.sv
// Bus interface unit: arbitrates fetch and data channels onto one Avalon-style
// master port. Data requests win over fetches. Misaligned requests skip the bus.
// Optional build macro MIPS_BUS_TIMEOUT_EN aborts a bus cycle after TIMEOUT_CYC
// waitrequest cycles; without it the unit waits on waitrequest indefinitely.
module mips_bus_if
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_signed,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  busy,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     readdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    state_e            state_q, state_d;
    chan_e             ch_q;
    logic [ADDR_W-1:0] addr_q;
    size_e             sz_q;
    logic              we_q, sgn_q;
    logic [DATA_W-1:0] wdata_q, d_rdata_q;
    logic [31:0]       if_rdata_q;
    logic              d_err_q;

    logic              any_req, in_mis, bus_exit, bus_act, to_hit;
    size_e             in_sz;
    logic [OFF_W-1:0]  in_off;

    logic [BE_W-1:0]   lane_be;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;
    logic              lane_mis;

    mips_bus_lane #(.DATA_W(DATA_W)) u_lane (
        .sz_i         (sz_q),
        .off_i        (addr_q[OFF_W-1:0]),
        .signed_i     (sgn_q),
        .wdata_i      (wdata_q),
        .rdata_i      (readdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_mis)
    );

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Count stalled bus cycles; cleared in IDLE so every bus cycle starts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            to_cnt_q <= '0;
        end else if (state_q == BUS && waitrequest) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign to_hit = (state_q == BUS) && waitrequest && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign any_req  = d_req || if_req;
    assign bus_exit = !waitrequest || to_hit;

    // Request decode and next-state selection.
    always_comb begin
        state_d = state_q;
        in_sz   = d_req ? size_e'(d_size) : SZ_WORD;
        in_off  = d_req ? d_addr[OFF_W-1:0] : if_addr[OFF_W-1:0];
        in_mis  = is_misaligned(in_sz, 3'(in_off), DATA_W == 64);
        case (state_q)
            IDLE:    if (any_req) state_d = in_mis ? DONE : BUS;
            BUS:     if (bus_exit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, request latch, and result registers updated on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ch_q       <= CH_IF;
            addr_q     <= '0;
            sz_q       <= SZ_BYTE;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
            if_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (any_req) begin
                    ch_q    <= d_req ? CH_D : CH_IF;
                    addr_q  <= d_req ? d_addr : if_addr;
                    sz_q    <= in_sz;
                    we_q    <= d_req && d_we;
                    sgn_q   <= d_req && d_signed;
                    wdata_q <= d_wdata;
                    if (in_mis) begin
                        if (d_req) begin
                            d_err_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            if_rdata_q <= '0;
                        end
                    end
                end
                // waitrequest still high on exit can only mean a timeout abort.
                BUS: if (bus_exit) begin
                    if (ch_q == CH_D) begin
                        d_err_q   <= waitrequest;
                        d_rdata_q <= (we_q || waitrequest) ? '0 : lane_rdata;
                    end else begin
                        if_rdata_q <= waitrequest ? 32'd0 : lane_rdata[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Misaligned requests never reach BUS; the lane check only guards the strobes.
    assign bus_act    = (state_q == BUS) && !lane_mis;
    assign read       = bus_act && !we_q;
    assign write      = bus_act && we_q;
    assign address    = bus_act ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
    assign byteenable = bus_act ? lane_be : '0;
    assign writedata  = (bus_act && we_q) ? lane_wdata : '0;

    assign busy     = (state_q != IDLE);
    assign d_ack    = (state_q == DONE) && (ch_q == CH_D);
    assign if_ack   = (state_q == DONE) && (ch_q == CH_IF);
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;
    assign if_rdata = if_rdata_q;

endmodule

// File: tb/tb_mips_bus_if.sv
module tb_mips_bus_if;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ack, d_err, busy, read, write;
    logic [31:0] d_rdata, address, writedata;
    logic        waitrequest = 1'b0;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mips_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .d_err(d_err), .busy(busy), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (32-bit bus, little-endian) ----------------
    function automatic int nbytes(input int sz);
        return 1 << sz;
    endfunction

    function automatic bit exp_mis(input int sz, input logic [31:0] a);
        if (sz == 3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
        int off = int'(a % 4);
        logic [3:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + nbytes(sz)) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_wd(input int sz, input logic [31:0] a, input logic [31:0] wd);
        logic [63:0] m = (64'd1 << (8 * nbytes(sz))) - 64'd1;
        logic [63:0] v = ({32'd0, wd} & m) << (8 * (a % 4));
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_ld(input int sz, input logic [31:0] a, input bit sgn,
                                           input logic [31:0] rd);
        logic [63:0] m = (64'd1 << (8 * nbytes(sz))) - 64'd1;
        logic [63:0] v = ({32'd0, rd} >> (8 * (a % 4))) & m;
        if (sgn && v[8 * nbytes(sz) - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    // ---------------- transaction driver (acts as requester and slave) ----------------
    task automatic run_xact(input bit is_d, input bit we, input int sz, input bit sgn,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int nwait,
                            output int lat, output int nstrobe, output logic [31:0] rdata,
                            output bit err, output logic [31:0] addr_s, output logic [3:0] be_s,
                            output logic [31:0] wd_s, output bit rd_s, output bit wr_s,
                            output bit unstable, output bit extra_ack, output bit got);
        int wl;
        lat = 0; nstrobe = 0; got = 0; unstable = 0; rd_s = 0; wr_s = 0;
        addr_s = '0; be_s = '0; wd_s = '0; rdata = '0; err = 0; extra_ack = 0;
        wl = nwait;
        waitrequest = (wl > 0);
        readdata = rd;
        if (is_d) begin
            d_we = we; d_size = 2'(sz); d_signed = sgn; d_addr = a; d_wdata = wd; d_req = 1'b1;
        end else begin
            if_addr = a; if_req = 1'b1;
        end
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (read || write) begin
                if (nstrobe == 0) begin
                    addr_s = address; be_s = byteenable; wd_s = writedata;
                end else if (address !== addr_s || byteenable !== be_s || writedata !== wd_s) begin
                    unstable = 1'b1;
                end
                rd_s |= read;
                wr_s |= write;
                nstrobe++;
            end
            if (is_d ? d_ack : if_ack) begin
                got = 1'b1;
                rdata = is_d ? d_rdata : if_rdata;
                err = is_d ? d_err : 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (nstrobe > 0 && wl > 0) begin
                wl--;
                waitrequest = (wl > 0);
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        extra_ack = d_ack || if_ack;
        @(posedge clk);
        #1;
    endtask

    int lat, ns;
    logic [31:0] rdv, as, ws;
    logic [3:0] bs;
    bit er, rs, wsb, unst, xack, got;

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({read, write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {read, write}); end
        n_cmp++; if (address !== 32'd0 || byteenable !== 4'd0 || writedata !== 32'd0) begin
            n_bad++; $display("FAIL reset_bus: addr %h be %h wd %h want zeros", address, byteenable, writedata); end
        n_cmp++; if ({d_ack, if_ack, d_err} !== 3'b000 || d_rdata !== 32'd0 || if_rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_resp: acks/err %b d_rdata %h if_rdata %h want zeros",
                              {d_ack, if_ack, d_err}, d_rdata, if_rdata); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load();
        run_xact(1, 0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (!got || lat != 3) begin n_bad++; $display("FAIL word_load_latency: got %0d (ack %b) want 3", lat, got); end
        n_cmp++; if (bs !== 4'hF || as !== 32'h100) begin n_bad++; $display("FAIL word_load_bus: be %h addr %h want f 100", bs, as); end
        n_cmp++; if (rdv !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL word_load_data: got %h err %b want deadbeef 0", rdv, er); end
        n_cmp++; if (rs !== 1'b1 || wsb !== 1'b0 || ns != 1) begin n_bad++; $display("FAIL word_load_strobe: rd %b wr %b n %0d want 1 0 1", rs, wsb, ns); end
    endtask

    task automatic test_byte_load();
        run_xact(1, 0, 0, 1, 32'h103, 32'h0, 32'h80123456, 0, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (bs !== 4'b1000 || as !== 32'h100) begin n_bad++; $display("FAIL sbyte_bus: be %b addr %h want 1000 100", bs, as); end
        n_cmp++; if (!got || rdv !== 32'hFFFFFF80) begin n_bad++; $display("FAIL sbyte_data: got %h want ffffff80", rdv); end
        run_xact(1, 0, 0, 0, 32'h103, 32'h0, 32'h80123456, 0, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (!got || rdv !== 32'h00000080) begin n_bad++; $display("FAIL ubyte_data: got %h want 00000080", rdv); end
    endtask

    task automatic test_half_store();
        run_xact(1, 1, 1, 0, 32'h202, 32'h0000ABCD, 32'h0, 4, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (ns != 5 || wsb !== 1'b1 || rs !== 1'b0) begin n_bad++; $display("FAIL hstore_strobe: n %0d wr %b rd %b want 5 1 0", ns, wsb, rs); end
        n_cmp++; if (ws !== 32'hABCD0000 || bs !== 4'b1100 || as !== 32'h200) begin
            n_bad++; $display("FAIL hstore_bus: wd %h be %b addr %h want abcd0000 1100 200", ws, bs, as); end
        n_cmp++; if (!got || lat != 7) begin n_bad++; $display("FAIL hstore_latency: got %0d want 7", lat); end
        n_cmp++; if (unst || er !== 1'b0) begin n_bad++; $display("FAIL hstore_hold: unstable %b err %b want 0 0", unst, er); end
    endtask

    task automatic test_misaligned();
        run_xact(1, 0, 2, 0, 32'h101, 32'h0, 32'h11223344, 0, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL misal_strobe: got %0d strobe cycles want 0", ns); end
        n_cmp++; if (!got || lat != 2 || er !== 1'b1) begin n_bad++; $display("FAIL misal_ack: lat %0d err %b want 2 1", lat, er); end
        run_xact(1, 0, 2, 0, 32'h104, 32'h0, 32'h11223344, 0, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (er !== 1'b0 || rdv !== 32'h11223344) begin n_bad++; $display("FAIL err_clear: err %b data %h want 0 11223344", er, rdv); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            bit we = 1'($urandom_range(0, 1));
            bit sg = 1'($urandom_range(0, 1));
            int sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            int nw = int'($urandom_range(0, 3));
            logic [31:0] a = $urandom();
            logic [31:0] wd = $urandom();
            logic [31:0] rd = $urandom();
            bit mis;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
            mis = exp_mis(sz, a);
            run_xact(1, we, sz, sg, a, wd, rd, nw, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
            n_cmp++; if (!got || lat != (mis ? 2 : 3 + nw) || er !== mis) begin
                n_bad++; $display("FAIL rnd_ack[%0d]: lat %0d err %b want %0d %b", t, lat, er, mis ? 2 : 3 + nw, mis); end
            n_cmp++; if (ns != (mis ? 0 : nw + 1) || unst || xack) begin
                n_bad++; $display("FAIL rnd_strobe[%0d]: n %0d unstable %b extra_ack %b want %0d 0 0", t, ns, unst, xack, mis ? 0 : nw + 1); end
            if (!mis) begin
                n_cmp++; if (as !== (a & ~32'd3) || bs !== exp_be(sz, a) || rs !== !we || wsb !== we) begin
                    n_bad++; $display("FAIL rnd_bus[%0d]: addr %h be %b rd %b wr %b want %h %b %b %b",
                                      t, as, bs, rs, wsb, a & ~32'd3, exp_be(sz, a), !we, we); end
                n_cmp++;
                if (we ? (ws !== exp_wd(sz, a, wd)) : (rdv !== exp_ld(sz, a, sg, rd))) begin
                    n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", t, we ? ws : rdv,
                                      we ? exp_wd(sz, a, wd) : exp_ld(sz, a, sg, rd)); end
            end
        end
    endtask

    task automatic test_fetch();
        for (int t = 0; t < 6; t++) begin
            logic [31:0] a = $urandom() & ~32'd3;
            logic [31:0] rd = $urandom() | 32'h1;
            int nw = int'($urandom_range(0, 2));
            run_xact(0, 0, 2, 0, a, 32'h0, rd, nw, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
            n_cmp++; if (!got || lat != 3 + nw || rdv !== rd) begin
                n_bad++; $display("FAIL fetch[%0d]: lat %0d data %h want %0d %h", t, lat, rdv, 3 + nw, rd); end
            n_cmp++; if (as !== a || bs !== 4'hF || rs !== 1'b1 || wsb !== 1'b0) begin
                n_bad++; $display("FAIL fetch_bus[%0d]: addr %h be %h rd %b wr %b want %h f 1 0", t, as, bs, rs, wsb, a); end
        end
        run_xact(0, 0, 2, 0, 32'h1002, 32'h0, 32'h55AA55AA, 0, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (!got || lat != 2 || ns != 0 || rdv !== 32'd0) begin
            n_bad++; $display("FAIL fetch_misal: lat %0d strobes %0d data %h want 2 0 0", lat, ns, rdv); end
    endtask

    task automatic test_simultaneous();
        int d_at = -1, i_at = -1;
        bit both = 0;
        logic [31:0] a1 = '0, a2 = '0, dr = '0, ir = '0;
        d_we = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h340; if_addr = 32'h1000;
        readdata = 32'h12345678; waitrequest = 1'b0;
        d_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 30 && i_at < 0; c++) begin
            @(negedge clk);
            if (read && write) both = 1'b1;
            if (read || write) begin
                if (d_at < 0) a1 = address; else a2 = address;
            end
            if (d_ack && if_ack) both = 1'b1;
            if (d_ack && d_at < 0) begin d_at = c; dr = d_rdata; end
            if (if_ack && i_at < 0) begin i_at = c; ir = if_rdata; end
            @(posedge clk);
            #1;
            if (d_at == c) d_req = 1'b0;
            if (i_at == c) if_req = 1'b0;
        end
        d_req = 1'b0; if_req = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (d_at != 2 || i_at != 5 || both) begin
            n_bad++; $display("FAIL simul_order: d_ack@%0d if_ack@%0d overlap %b want 2 5 0", d_at, i_at, both); end
        n_cmp++; if (a1 !== 32'h340 || a2 !== 32'h1000) begin
            n_bad++; $display("FAIL simul_addr: first %h second %h want 340 1000", a1, a2); end
        n_cmp++; if (dr !== 32'h12345678 || ir !== 32'h12345678) begin
            n_bad++; $display("FAIL simul_data: d %h if %h want 12345678", dr, ir); end
    endtask

    task automatic test_reset_mid();
        bit acked = 0;
        d_we = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h500; waitrequest = 1'b1;
        d_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (read !== 1'b1 || address !== 32'h500) begin
            n_bad++; $display("FAIL rstmid_pre: read %b addr %h want 1 500", read, address); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (read !== 1'b0 || address !== 32'd0 || byteenable !== 4'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_clear: read %b addr %h be %h busy %b want zeros", read, address, byteenable, busy); end
        d_req = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_ack || if_ack || read || write) acked = 1'b1;
        end
        n_cmp++; if (acked) begin n_bad++; $display("FAIL rstmid_noack: got activity 1 want 0"); end
        @(posedge clk);
        #1;
    endtask

`ifdef MIPS_BUS_TIMEOUT_EN
    task automatic test_timeout();
        run_xact(1, 0, 2, 0, 32'h600, 32'h0, 32'h0, 1000, lat, ns, rdv, er, as, bs, ws, rs, wsb, unst, xack, got);
        n_cmp++; if (!got || ns != 8 || er !== 1'b1) begin
            n_bad++; $display("FAIL timeout: ack %b strobes %0d err %b want 1 8 1", got, ns, er); end
    endtask
`endif

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_random();
        test_fetch();
        test_simultaneous();
        test_reset_mid();
`ifdef MIPS_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
